// File: rtl/fx2_slave_fifo_model_if.sv
// FX2 slave-FIFO strobes/flags plus the host-side valid/ready streams.
// master = FPGA/host driver side, slave = the FIFO model.
interface fx2_slave_fifo_model_if;
    logic [2:0]  fx2_flags;
    logic        fx2_sloe_b;
    logic        fx2_slrd_b;
    logic        fx2_slwr_b;
    logic        fx2_pktend_b;
    logic [1:0]  fx2_fifo_addr;
    logic [15:0] host_out_data;
    logic        host_out_valid;
    logic        host_out_ready;
    logic [15:0] host_in_data;
    logic        host_in_last;
    logic        host_in_valid;
    logic        host_in_ready;

    modport master (
        input  fx2_flags, host_out_ready,
        input  host_in_data, host_in_last, host_in_valid,
        output fx2_sloe_b, fx2_slrd_b, fx2_slwr_b, fx2_pktend_b,
        output fx2_fifo_addr, host_out_data, host_out_valid,
        output host_in_ready
    );

    modport slave (
        output fx2_flags, host_out_ready,
        output host_in_data, host_in_last, host_in_valid,
        input  fx2_sloe_b, fx2_slrd_b, fx2_slwr_b, fx2_pktend_b,
        input  fx2_fifo_addr, host_out_data, host_out_valid,
        input  host_in_ready
    );
endinterface

// File: rtl/fx2_slave_fifo_model.sv
// Cycle-level FX2 slave-FIFO model: EP2 (host->FPGA) and EP6 (FPGA->host).
// Define FX2_FLAG_DELAY_EN to register fx2_flags one extra cycle.
module fx2_slave_fifo_model #(
    parameter int OUT_AW       = 9,
    parameter int IN_AW        = 9,
    parameter int PKT_WORDS    = 256,
    parameter int AFULL_THRESH = 4
) (
    input  logic                ifclk,
    input  logic                resetb,
    fx2_slave_fifo_model_if.slave bus,
    inout  wire  [15:0]         fx2_fd,
    output logic                err_underflow,
    output logic                err_overflow,
    output logic [7:0]          zlp_count
);

    localparam int OW = OUT_AW + 1;
    localparam int IW = IN_AW + 1;
    localparam int PW = $clog2(PKT_WORDS) + 1;
    localparam logic [OW-1:0] OUT_FULL = {1'b1, {OUT_AW{1'b0}}};
    localparam logic [IW-1:0] IN_FULL  = {1'b1, {IN_AW{1'b0}}};
    localparam logic [PW-1:0] PKT_M1   = PW'(PKT_WORDS - 1);

    logic [15:0]       out_mem [1 << OUT_AW];
    logic [OUT_AW-1:0] out_wp;
    logic [OUT_AW-1:0] out_rp;
    logic [OW-1:0]     out_cnt;
    logic [15:0]       out_last;

    // bit 16 marks the word that closes a packet
    logic [16:0]       in_mem [1 << IN_AW];
    logic [IN_AW-1:0]  in_wp;
    logic [IN_AW-1:0]  in_rp;
    logic [IW-1:0]     in_cnt;
    logic [IW-1:0]     in_ccnt;
    logic [PW-1:0]     pend;
    logic [PW-1:0]     commit_n;

    logic        sel_ep2;
    logic        sel_ep6;
    logic        out_empty;
    logic        out_push;
    logic        rd_req;
    logic        out_pop;
    logic        fd_oe;
    logic [15:0] fd_out;
    logic        in_full;
    logic        wr_req;
    logic        in_wr;
    logic        pe_req;
    logic        wr_last;
    logic        mark;
    logic        zlp;
    logic        in_pop;
    logic [IW-1:0] in_free;
    logic [2:0]  flags_c;

    assign sel_ep2   = bus.fx2_fifo_addr == 2'b00;
    assign sel_ep6   = bus.fx2_fifo_addr == 2'b10;

    assign out_empty = out_cnt == '0;
    assign bus.host_out_ready = out_cnt != OUT_FULL;
    assign out_push  = bus.host_out_valid && bus.host_out_ready;
    assign rd_req    = !bus.fx2_slrd_b && sel_ep2;
    assign out_pop   = rd_req && !out_empty;

    // an empty EP2 keeps presenting the last word it handed out
    assign fd_oe  = !bus.fx2_sloe_b && sel_ep2;
    assign fd_out = out_empty ? out_last : out_mem[out_rp];
    assign fx2_fd = fd_oe ? fd_out : 'z;

    assign in_full = in_cnt == IN_FULL;
    assign wr_req  = !bus.fx2_slwr_b && sel_ep6;
    assign in_wr   = wr_req && !in_full;
    assign pe_req  = !bus.fx2_pktend_b && sel_ep6;
    assign wr_last = in_wr && (pend == PKT_M1 || pe_req);
    assign mark    = pe_req && !in_wr && pend != '0;
    assign zlp     = pe_req && !in_wr && pend == '0;
    assign in_pop  = bus.host_in_valid && bus.host_in_ready;

    always_comb begin
        commit_n = '0;
        if (wr_last)
            commit_n = pend + 1'b1;
        else if (mark)
            commit_n = pend;
    end

    assign bus.host_in_valid = in_ccnt != '0;
    assign bus.host_in_data  = bus.host_in_valid ? in_mem[in_rp][15:0] : 16'h0;
    assign bus.host_in_last  = bus.host_in_valid && in_mem[in_rp][16];

    assign in_free = IN_FULL - in_cnt;
    assign flags_c = {in_free > IW'(AFULL_THRESH), !in_full, !out_empty};

`ifdef FX2_FLAG_DELAY_EN
    logic [2:0] flags_q;

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb)
            flags_q <= 3'b110;
        else
            flags_q <= flags_c;
    end

    assign bus.fx2_flags = flags_q;
`else
    assign bus.fx2_flags = flags_c;
`endif

    always_ff @(posedge ifclk) begin
        if (out_push)
            out_mem[out_wp] <= bus.host_out_data;
        if (in_wr)
            in_mem[in_wp] <= {wr_last, fx2_fd};
        if (mark)
            in_mem[in_wp - 1'b1][16] <= 1'b1;
    end

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            out_wp        <= '0;
            out_rp        <= '0;
            out_cnt       <= '0;
            out_last      <= '0;
            in_wp         <= '0;
            in_rp         <= '0;
            in_cnt        <= '0;
            in_ccnt       <= '0;
            pend          <= '0;
            err_underflow <= 1'b0;
            err_overflow  <= 1'b0;
            zlp_count     <= '0;
        end else begin
            if (out_push)
                out_wp <= out_wp + 1'b1;
            if (out_pop) begin
                out_rp   <= out_rp + 1'b1;
                out_last <= out_mem[out_rp];
            end
            out_cnt <= out_cnt + OW'(out_push) - OW'(out_pop);
            if (rd_req && out_empty)
                err_underflow <= 1'b1;

            if (in_wr)
                in_wp <= in_wp + 1'b1;
            if (in_pop)
                in_rp <= in_rp + 1'b1;
            in_cnt  <= in_cnt + IW'(in_wr) - IW'(in_pop);
            in_ccnt <= in_ccnt + IW'(commit_n) - IW'(in_pop);
            if (wr_req && in_full)
                err_overflow <= 1'b1;
            if (zlp)
                zlp_count <= zlp_count + 8'd1;
            if (wr_last || mark)
                pend <= '0;
            else if (in_wr)
                pend <= pend + 1'b1;
        end
    end

endmodule

// File: doc/fx2_slave_fifo_model.md
Name: fx2_slave_fifo_model

Overview:
- Cycle-level model of the FX2 slave-FIFO, the device end of the fx2_* bus that HostInterface masters.
- Holds EP2 (OUT: host to FPGA) and EP6 (IN: FPGA to host) word FIFOs.
- Drives the FX2 flags and fx2_fd, and obeys the FPGA's sloe/slrd/slwr/pktend strobes.
- Host side is two valid/ready streams. Used as the testbench counterpart to the FPGA top.

Parameters:
- OUT_AW, 9, log2 of EP2 depth in 16-bit words.
- IN_AW, 9, log2 of EP6 depth in 16-bit words.
- PKT_WORDS, 256, EP6 auto-commit packet size in words.
- AFULL_THRESH, 4, EP6 almost-full asserts when free words <= this.

Ports:
- ifclk  in  1  clock; all state changes on posedge.
- resetb  in  1  asynchronous active-low reset.
- fx2_flags  out  3  [0] EP2 empty_b, [1] EP6 full_b, [2] EP6 almost_full_b; all active-low.
- fx2_sloe_b  in  1  output enable, active-low.
- fx2_slrd_b  in  1  read strobe, active-low.
- fx2_slwr_b  in  1  write strobe, active-low.
- fx2_pktend_b  in  1  packet end, active-low.
- fx2_fifo_addr  in  2  2'b00 selects EP2, 2'b10 selects EP6; other codes select nothing.
- fx2_fd  inout  16  data bus.
- host_out_data  in  16  word to push into EP2.
- host_out_valid  in  1  push request.
- host_out_ready  out  1  high when EP2 is not full.
- host_in_data  out  16  EP6 head word.
- host_in_last  out  1  head word ends a packet.
- host_in_valid  out  1  committed EP6 data available.
- host_in_ready  in  1  pop acknowledge.
- err_underflow  out  1  sticky.
- err_overflow  out  1  sticky.
- zlp_count  out  8  count of zero-length packets, wraps.

Behaviour:
- Reset (async assert, sync release), applied at any time including mid-packet:
  - all pointers 0; partial packets discarded; errors 0; zlp_count 0.
  - fx2_flags=3'b110; fx2_fd high-Z; host_out_ready=1; host_in_valid=0; host_in_last=0; host_in_data=0.
- EP2 (OUT):
  - Host push when host_out_valid && host_out_ready.
  - fx2_fd is driven with the EP2 head word only while !fx2_sloe_b && fx2_fifo_addr==00; high-Z otherwise.
  - When EP2 is empty and the bus is driven, fx2_fd holds the last popped word (0 after reset).
  - Pop on posedge when !fx2_slrd_b && addr==00 && not empty. The next head word is on fx2_fd after that edge.
  - Pop attempt on empty: ignored, err_underflow set.
  - Push and pop in the same cycle are both honoured; count unchanged.
- EP6 (IN):
  - Write on posedge when !fx2_slwr_b && addr==10 && not full: store fx2_fd plus a last bit.
  - Write attempt on full: word dropped, err_overflow set.
  - Uncommitted words count up. When the count reaches PKT_WORDS, that word's last bit is set and the packet commits.
  - pktend (!fx2_pktend_b && addr==10 on posedge):
    - With a concurrent accepted write, that word is last.
    - Otherwise the most recent uncommitted word gets last=1.
    - With zero uncommitted words, zlp_count increments and no data is stored.
  - Committing advances the commit pointer.
  - host_in_valid = read pointer != commit pointer. Pop on host_in_valid && host_in_ready.
- Flags are combinational from post-edge state, so they reflect an edge's effects in the same cycle:
  - EP2 empty_b=0 when EP2 count==0.
  - EP6 full_b=0 when count==2^IN_AW.
  - almost_full_b=0 when free words <= AFULL_THRESH.
  - Full and free counts include uncommitted words.
- Strobes with addr 01/11 are ignored with no error.
- slrd with addr 10, or slwr/pktend with addr 00, are ignored.
- Counters use AW+1 bits; pointers wrap modulo depth.

Optional Feature:
- FX2_FLAG_DELAY_EN defined:
  - fx2_flags pass through one extra register stage, giving 1-cycle-stale flags as on silicon.
  - The reset value of that register is 3'b110.
  - Overflow/underflow protection still uses the true internal state.
- Not defined: flags are combinational as specified above.

Test Plan:
- Host pushes 0x1000..0x1003; FPGA pulls 4 words with sloe/slrd low at addr 00 -> fd reads 0x1000..0x1003; flags[0] falls to 0 after the 4th pop; err_underflow=0.
- FPGA writes 3 words 0xA0..0xA2, then pulses pktend -> host sees 3 words, last=1 only on 0xA2; host_in_valid stays 0 before pktend.
- FPGA writes 256 words with no pktend -> auto-commit; word 255 has last=1; a following pktend with zero pending -> zlp_count=1.
- Fill EP6 with IN_AW=4 (16 words) -> flags[2]=0 once free words <= 4; flags[1]=0 at 16; 17th write dropped, err_overflow=1.
- slrd on empty EP2 -> err_underflow=1, pointers unchanged; assert resetb mid-packet -> flags=3'b110, EP6 empty, errors cleared.
- With FX2_FLAG_DELAY_EN, first host push -> flags[0] rises one cycle later than without the macro.
